// File: rtl/vector_alu_pipe.sv
// rtl/vector_alu_pipe.sv - elastic two-stage N-lane vector ALU with per-lane overflow flags
// S1 registers operands; lane arithmetic sits between S1 and S2; S2 holds the result beat.
module vector_alu_pipe #(
  parameter int N_LANES = 16,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic              in_signed,
  input  logic [DATA_W-1:0] in_a [N_LANES],
  input  logic [DATA_W-1:0] in_b [N_LANES],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_c [N_LANES],
  output logic [N_LANES-1:0] out_ovf,
  output logic [CNT_W-1:0]  beat_count
);

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_ADD_SAT = 3'b010;
  localparam logic [2:0] OP_SUB_SAT = 3'b011;
  localparam logic [2:0] OP_MIN     = 3'b100;
  localparam logic [2:0] OP_MAX     = 3'b101;

  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] UMAX = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};

  logic              s1_valid;
  logic [2:0]        s1_op;
  logic              s1_signed;
  logic [DATA_W-1:0] s1_a [N_LANES];
  logic [DATA_W-1:0] s1_b [N_LANES];

  logic [DATA_W-1:0]  res_c [N_LANES];
  logic [N_LANES-1:0] res_ovf;

  logic s2_advance;
  logic s1_advance;
  logic in_accept;

  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = rst_n && s1_advance;
  assign in_accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_advance) begin
      s1_valid <= in_accept;
    end
  end

  // Operand registers carry no state worth resetting; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (in_accept) begin
      s1_op     <= in_op;
      s1_signed <= in_signed;
      for (int i = 0; i < N_LANES; i++) begin
        s1_a[i] <= in_a[i];
        s1_b[i] <= in_b[i];
      end
    end
  end

  // Operands are extended by one bit so sum/diff are exact for both signednesses.
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [DATA_W:0]   a_e;
    logic [DATA_W:0]   b_e;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic              add_ovf;
    logic              sub_ovf;
    logic              a_lt_b;
    logic [DATA_W-1:0] lane_c;
    logic              lane_ovf;

    assign a_e     = {s1_signed & s1_a[i][DATA_W-1], s1_a[i]};
    assign b_e     = {s1_signed & s1_b[i][DATA_W-1], s1_b[i]};
    assign sum     = a_e + b_e;
    assign diff    = a_e - b_e;
    assign add_ovf = s1_signed ? (sum[DATA_W] ^ sum[DATA_W-1]) : sum[DATA_W];
    assign sub_ovf = s1_signed ? (diff[DATA_W] ^ diff[DATA_W-1]) : diff[DATA_W];
    assign a_lt_b  = diff[DATA_W];

    always_comb begin
      lane_c   = s1_a[i];
      lane_ovf = 1'b0;
      case (s1_op)
        OP_ADD: begin
          lane_c   = sum[DATA_W-1:0];
          lane_ovf = add_ovf;
        end
        OP_SUB: begin
          lane_c   = diff[DATA_W-1:0];
          lane_ovf = sub_ovf;
        end
        OP_ADD_SAT: begin
          lane_ovf = add_ovf;
          if (!add_ovf)       lane_c = sum[DATA_W-1:0];
          else if (s1_signed) lane_c = sum[DATA_W] ? SMIN : SMAX;
          else                lane_c = UMAX;
        end
        OP_SUB_SAT: begin
          lane_ovf = sub_ovf;
          if (!sub_ovf)       lane_c = diff[DATA_W-1:0];
          else if (s1_signed) lane_c = diff[DATA_W] ? SMIN : SMAX;
          else                lane_c = ZERO;
        end
        OP_MIN:  lane_c = a_lt_b ? s1_a[i] : s1_b[i];
        OP_MAX:  lane_c = a_lt_b ? s1_b[i] : s1_a[i];
        default: lane_c = s1_a[i];
      endcase
    end

    assign res_c[i]   = lane_c;
    assign res_ovf[i] = lane_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ovf   <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        out_c[i] <= '0;
      end
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_ovf <= res_ovf;
        for (int i = 0; i < N_LANES; i++) begin
          out_c[i] <= res_c[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count <= '0;
    end else if (out_valid && out_ready) begin
      beat_count <= beat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vector_alu_pipe.sv
// tb/tb_vector_alu_pipe.sv - directed bench for vector_alu_pipe
// A second instance with a 4-bit beat counter shares all inputs to exercise counter wrap.
module tb_vector_alu_pipe;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_ADD_SAT = 3'b010;
  localparam logic [2:0] OP_SUB_SAT = 3'b011;
  localparam logic [2:0] OP_MIN     = 3'b100;
  localparam logic [2:0] OP_MAX     = 3'b101;
  localparam logic [2:0] OP_RSV     = 3'b110;

  typedef struct packed {
    logic [2:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        ovf;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready2;
  logic [2:0]  in_op;
  logic        in_signed;
  logic [31:0] in_a [16];
  logic [31:0] in_b [16];
  logic        out_valid;
  logic        out_valid2;
  logic        out_ready;
  logic [31:0] out_c [16];
  logic [31:0] out_c2 [16];
  logic [15:0] out_ovf;
  logic [15:0] out_ovf2;
  logic [15:0] beat_count;
  logic [3:0]  beat_count2;

  int total;
  int bad;
  int exp_count;

  vector_alu_pipe #(.N_LANES(16), .DATA_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_signed(in_signed), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_ovf(out_ovf), .beat_count(beat_count)
  );

  vector_alu_pipe #(.N_LANES(16), .DATA_W(32), .CNT_W(4)) u_dut_cnt4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_signed(in_signed), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid2), .out_ready(out_ready), .out_c(out_c2),
    .out_ovf(out_ovf2), .beat_count(beat_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_bcast(input logic [2:0] op, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b);
    in_op     = op;
    in_signed = sgn;
    for (int i = 0; i < 16; i++) begin
      in_a[i] = a;
      in_b[i] = b;
    end
  endtask

  task automatic issue();
    bit rdy;
    int n;
    @(posedge clk);
    #1 in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    #1 in_valid = 1'b0;
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL issue_timeout got in_ready=0 need 1 within 50 cycles");
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL out_timeout got out_valid=0 need 1 within 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_bcast(OP_ADD, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    total++; if (beat_count !== 16'h0) begin bad++; $display("FAIL rst_beat_count got %h exp 0", beat_count); end
    total++; if (out_ovf !== 16'h0)   begin bad++; $display("FAIL rst_out_ovf got %h exp 0", out_ovf); end
    total++; if (out_c[5] !== 32'h0)  begin bad++; $display("FAIL rst_out_c got %h exp 0", out_c[5]); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
    exp_count = 0;
  endtask

  task automatic test_add_latency();
    int errs;
    set_bcast(OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready got %b exp 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early got out_valid=%b exp 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got out_valid=%b exp 1", out_valid); end
    errs = 0;
    for (int i = 0; i < 16; i++) if (out_c[i] !== 32'h0) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL add_wrap_c got %h exp 00000000 (%0d lanes)", out_c[0], errs); end
    total++; if (out_ovf !== 16'hFFFF) begin bad++; $display("FAIL add_wrap_ovf got %h exp ffff", out_ovf); end
    exp_count++;
    @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_drain got out_valid=%b exp 0", out_valid); end
    total++; if (beat_count !== 16'(exp_count)) begin bad++; $display("FAIL lat_count got %0d exp %0d", beat_count, exp_count); end
  endtask

  task automatic test_ops();
    vec_t v [14];
    int errs;
    v[0]  = '{OP_ADD_SAT, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
    v[1]  = '{OP_SUB_SAT, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1};
    v[2]  = '{OP_SUB_SAT, 1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 1'b1};
    v[3]  = '{OP_SUB,     1'b0, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1};
    v[4]  = '{OP_ADD,     1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
    v[5]  = '{OP_ADD,     1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    v[6]  = '{OP_SUB,     1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0};
    v[7]  = '{OP_ADD_SAT, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 32'hFFFF_FFFF, 1'b1};
    v[8]  = '{OP_ADD_SAT, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0};
    v[9]  = '{OP_MIN,     1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    v[10] = '{OP_MIN,     1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    v[11] = '{OP_MAX,     1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    v[12] = '{OP_MAX,     1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    v[13] = '{OP_SUB_SAT, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    for (int k = 0; k < 14; k++) begin
      set_bcast(v[k].op, v[k].sgn, v[k].a, v[k].b);
      issue();
      wait_out();
      errs = 0;
      for (int i = 0; i < 16; i++) if (out_c[i] !== v[k].c) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL ops_c[%0d] got %h exp %h", k, out_c[0], v[k].c); end
      total++; if (out_ovf !== {16{v[k].ovf}}) begin bad++; $display("FAIL ops_ovf[%0d] got %h exp %h", k, out_ovf, {16{v[k].ovf}}); end
      exp_count++;
    end
    @(posedge clk);
    @(negedge clk);
    total++; if (beat_count !== 16'(exp_count)) begin bad++; $display("FAIL ops_count got %0d exp %0d", beat_count, exp_count); end
  endtask

  task automatic load_stream(input int b);
    in_op     = OP_ADD;
    in_signed = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_a[i] = 32'(b * 16 + i);
      in_b[i] = 32'(i);
    end
  endtask

  task automatic test_back_to_back();
    int got, order_err, sent;
    bit stall_seen, illegal_stall, unstable, held_v;
    logic [31:0] held;
    got = 0; order_err = 0; sent = 0;
    stall_seen = 0; illegal_stall = 0; unstable = 0; held_v = 0; held = '0;
    @(posedge clk);
    #1;
    fork
      begin
        bit rdy;
        int guard;
        guard = 0;
        load_stream(0);
        in_valid = 1'b1;
        while (sent < 8 && guard < 60) begin
          @(negedge clk);
          rdy = in_ready;
          @(posedge clk);
          guard++;
          if (rdy) begin
            sent++;
            #1;
            if (sent < 8) load_stream(sent);
            else in_valid = 1'b0;
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(negedge clk);
          if (!in_ready) begin
            stall_seen = 1;
            if (out_ready) illegal_stall = 1;
          end
          if (out_valid && out_ready) begin
            for (int i = 0; i < 16; i++)
              if (out_c[i] !== 32'(got * 16 + 2 * i) || out_ovf[i] !== 1'b0) order_err++;
            got++;
          end
          if (out_valid && !out_ready) begin
            if (held_v && out_c[0] !== held) unstable = 1;
            held   = out_c[0];
            held_v = 1;
          end else begin
            held_v = 0;
          end
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    exp_count += 8;
    @(negedge clk);
    total++; if (sent != 8)      begin bad++; $display("FAIL stream_sent got %0d exp 8", sent); end
    total++; if (got != 8)       begin bad++; $display("FAIL stream_got got %0d exp 8", got); end
    total++; if (order_err != 0) begin bad++; $display("FAIL stream_order got %0d bad lanes exp 0", order_err); end
    total++; if (!stall_seen)    begin bad++; $display("FAIL stream_backpressure got in_ready never 0 exp drop"); end
    total++; if (illegal_stall)  begin bad++; $display("FAIL stream_ready got in_ready=0 with out_ready=1 exp 1"); end
    total++; if (unstable)       begin bad++; $display("FAIL stream_hold got changing out_c exp stable"); end
    total++; if (beat_count !== 16'(exp_count)) begin bad++; $display("FAIL stream_count got %0d exp %0d", beat_count, exp_count); end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    int errs;
    @(posedge clk);
    #1 out_ready = 1'b0;
    set_bcast(OP_ADD, 1'b0, 32'h1, 32'h1);
    issue();
    set_bcast(OP_ADD, 1'b0, 32'h2, 32'h2);
    issue();
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flight_full got out_valid=%b exp 1", out_valid); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
    total++; if (beat_count !== 16'h0) begin bad++; $display("FAIL mid_rst_count got %0d exp 0", beat_count); end
    total++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL mid_rst_ready got %b exp 0", in_ready); end
    total++; if (out_valid2 !== 1'b0)  begin bad++; $display("FAIL mid_rst_valid2 got %b exp 0", out_valid2); end
    exp_count = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL stale_beat got out_valid=1 after reset exp 0"); end
    set_bcast(OP_ADD, 1'b0, 32'h7, 32'h8);
    @(posedge clk);
    #1 in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_early got %b exp 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL post_rst_valid got %b exp 1", out_valid); end
    errs = 0;
    for (int i = 0; i < 16; i++) if (out_c[i] !== 32'd15) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL post_rst_c got %h exp 0000000f", out_c[0]); end
    exp_count++;
    @(posedge clk);
    @(negedge clk);
    total++; if (beat_count !== 16'(exp_count)) begin bad++; $display("FAIL post_rst_count got %0d exp %0d", beat_count, exp_count); end
  endtask

  task automatic test_reserved_wrap();
    int errs;
    in_op     = OP_RSV;
    in_signed = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_a[i] = 32'(i);
      in_b[i] = 32'hA5A5_0000 + 32'(i);
    end
    issue();
    wait_out();
    errs = 0;
    for (int i = 0; i < 16; i++) if (out_c[i] !== 32'(i)) errs++;
    total++; if (errs != 0)          begin bad++; $display("FAIL rsv_c got lane3=%h exp 00000003", out_c[3]); end
    total++; if (out_ovf !== 16'h0)  begin bad++; $display("FAIL rsv_ovf got %h exp 0", out_ovf); end
    total++; if (out_c2[3] !== 32'd3) begin bad++; $display("FAIL rsv_c2 got %h exp 00000003", out_c2[3]); end
    exp_count++;
    while (exp_count < 15) begin
      set_bcast(OP_ADD, 1'b0, 32'h10, 32'h1);
      issue();
      wait_out();
      exp_count++;
    end
    @(posedge clk);
    @(negedge clk);
    total++; if (beat_count2 !== 4'hF)  begin bad++; $display("FAIL cnt4_pre got %0d exp 15", beat_count2); end
    total++; if (beat_count !== 16'd15) begin bad++; $display("FAIL cnt16_pre got %0d exp 15", beat_count); end
    issue();
    wait_out();
    exp_count++;
    @(posedge clk);
    @(negedge clk);
    total++; if (beat_count2 !== 4'h0)  begin bad++; $display("FAIL cnt4_wrap got %0d exp 0", beat_count2); end
    total++; if (beat_count !== 16'd16) begin bad++; $display("FAIL cnt16_post got %0d exp 16", beat_count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_count = 0;
    test_reset();
    test_add_latency();
    test_ops();
    test_back_to_back();
    test_reset_midflight();
    test_reserved_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
